// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an N x N systolic MAC array: clear, skewed operand feed, drain, single-cycle store.
// Defining SYS_CTRL_PERF_CNT_EN adds the perf_cycles busy-cycle counter output.
module systolic_seq_ctrl #(
    parameter int N  = 2,
    parameter int DW = 32,
    parameter int AW = 8,
    parameter int CW = 11,
    parameter int KW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [KW-1:0]   k_len,
    input  logic [AW-1:0]   a_base,
    input  logic [AW-1:0]   w_base,
    input  logic [CW-1:0]   c_slot,
    output logic            busy,
    output logic            done,
    output logic [N*AW-1:0] ram_a_addr,
    output logic [N-1:0]    ram_a_rden,
    output logic [N*AW-1:0] ram_w_addr,
    output logic [N-1:0]    ram_w_rden,
    input  logic [N*DW-1:0] ram_a_q,
    input  logic [N*DW-1:0] ram_w_q,
    output logic [N*DW-1:0] a_in,
    output logic [N*DW-1:0] w_in,
    output logic [N*N-1:0]  en_mult,
    output logic [N*N-1:0]  clr_mult,
    output logic [N*N-1:0]  en_accum,
    output logic [N*N-1:0]  clr_accum,
    output logic [CW-1:0]   ram_c_addr,
    output logic [N*N-1:0]  ram_c_wren
`ifdef SYS_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]     perf_cycles
`endif
);
    localparam int TW = KW + $clog2(N) + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_STORE, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d, k_ext_s;
    logic [KW-1:0]   k_q, k_d;
    logic [AW-1:0]   a_base_q, a_base_d, w_base_q, w_base_d;
    logic [CW-1:0]   c_slot_q, c_slot_d, c_addr_q, c_addr_d;
    logic            busy_q, busy_d, done_q, done_d, vld0_q, vld0_d;
    logic [N*AW-1:0] a_addr_q, a_addr_d, w_addr_q, w_addr_d;
    logic [N-1:0]    rden_q, rden_d;
    logic [N*N-1:0]  en_mult_q, en_mult_d, en_accum_q, en_accum_d;
    logic [N*N-1:0]  clr_q, clr_d, wren_q, wren_d;
    logic            kill_s, run_d_s;

    // Sequencing: state, job-relative time t and the operands latched on accept.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        k_d      = k_q;
        a_base_d = a_base_q;
        w_base_d = w_base_q;
        c_slot_d = c_slot_q;
        k_ext_s  = TW'(k_q);
        kill_s   = abort && (state_q != S_IDLE) && (state_q != S_DONE);
        if (kill_s) begin
            state_d = S_IDLE;
            t_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    t_d = '0;
                    if (start) begin
                        k_d      = k_len;
                        a_base_d = a_base;
                        w_base_d = w_base;
                        c_slot_d = c_slot;
                        state_d  = (k_len == '0) ? S_DONE : S_CLEAR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CLEAR: begin
                    t_d     = '0;
                    state_d = S_FEED;
                end
                S_FEED: begin
                    t_d = t_q + TW'(1);
                    if (t_q == k_ext_s - TW'(1)) state_d = S_DRAIN;
                    else                         state_d = S_FEED;
                end
                S_DRAIN: begin
                    t_d = t_q + TW'(1);
                    if (t_q == k_ext_s + TW'(2*N-1)) state_d = S_STORE;
                    else                             state_d = S_DRAIN;
                end
                S_STORE: state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state/time so the registered copies line up with it.
    always_comb begin
        run_d_s    = (state_d == S_FEED) || (state_d == S_DRAIN);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        rden_d     = {N{state_d == S_FEED}};
        clr_d      = {(N*N){state_d == S_CLEAR}};
        wren_d     = {(N*N){state_d == S_STORE}};
        c_addr_d   = (state_d == S_STORE) ? c_slot_q : '0;
        vld0_d     = rden_q[0] && !kill_s;
        en_accum_d = run_d_s ? en_mult_q : '0;
        a_addr_d   = '0;
        w_addr_d   = '0;
        en_mult_d  = '0;
        for (int i = 0; i < N; i++) begin
            a_addr_d[i*AW +: AW] = (state_d == S_FEED) ? a_base_q + AW'(t_d) : '0;
            w_addr_d[i*AW +: AW] = (state_d == S_FEED) ? w_base_q + AW'(t_d) : '0;
            for (int j = 0; j < N; j++) begin
                en_mult_d[i*N+j] = run_d_s && (t_d >= TW'(1+i+j)) && (t_d <= k_ext_s + TW'(i+j));
            end
        end
    end

`ifdef SYS_CTRL_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle count: cleared on accept, saturating, frozen once the job leaves busy.
    always_comb begin
        if (state_q == S_IDLE && start) perf_d = 32'd0;
        else if (busy_q && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
        else perf_d = perf_q;
    end
    assign perf_cycles = perf_q;
`endif

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            k_q        <= '0;
            a_base_q   <= '0;
            w_base_q   <= '0;
            c_slot_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vld0_q     <= 1'b0;
            a_addr_q   <= '0;
            w_addr_q   <= '0;
            rden_q     <= '0;
            en_mult_q  <= '0;
            en_accum_q <= '0;
            clr_q      <= '0;
            wren_q     <= '0;
            c_addr_q   <= '0;
`ifdef SYS_CTRL_PERF_CNT_EN
            perf_q     <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            k_q        <= k_d;
            a_base_q   <= a_base_d;
            w_base_q   <= w_base_d;
            c_slot_q   <= c_slot_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            vld0_q     <= vld0_d;
            a_addr_q   <= a_addr_d;
            w_addr_q   <= w_addr_d;
            rden_q     <= rden_d;
            en_mult_q  <= en_mult_d;
            en_accum_q <= en_accum_d;
            clr_q      <= clr_d;
            wren_q     <= wren_d;
            c_addr_q   <= c_addr_d;
`ifdef SYS_CTRL_PERF_CNT_EN
            perf_q     <= perf_d;
`endif
        end
    end

    // Lane i (A row i and W column i) is delayed by i registers; lane 0 is the RAM output gated by valid.
    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_in[DW-1:0] = vld0_q ? ram_a_q[DW-1:0] : '0;
            assign w_in[DW-1:0] = vld0_q ? ram_w_q[DW-1:0] : '0;
        end else begin : g_pipe
            logic [DW-1:0] a_pipe_q [i];
            logic [DW-1:0] a_pipe_d [i];
            logic [DW-1:0] w_pipe_q [i];
            logic [DW-1:0] w_pipe_d [i];
            logic [i-1:0]  v_q, v_d;

            // Shift operands one stage per cycle; abort drops every in-flight valid bit.
            always_comb begin
                v_d         = '0;
                a_pipe_d[0] = ram_a_q[i*DW +: DW];
                w_pipe_d[0] = ram_w_q[i*DW +: DW];
                v_d[0]      = vld0_q && !kill_s;
                for (int s = 1; s < i; s++) begin
                    a_pipe_d[s] = a_pipe_q[s-1];
                    w_pipe_d[s] = w_pipe_q[s-1];
                    v_d[s]      = v_q[s-1] && !kill_s;
                end
            end

            // Skew pipe registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    for (int s = 0; s < i; s++) begin
                        a_pipe_q[s] <= '0;
                        w_pipe_q[s] <= '0;
                    end
                end else begin
                    v_q <= v_d;
                    for (int s = 0; s < i; s++) begin
                        a_pipe_q[s] <= a_pipe_d[s];
                        w_pipe_q[s] <= w_pipe_d[s];
                    end
                end
            end

            assign a_in[i*DW +: DW] = v_q[i-1] ? a_pipe_q[i-1] : '0;
            assign w_in[i*DW +: DW] = v_q[i-1] ? w_pipe_q[i-1] : '0;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ram_a_addr = a_addr_q;
    assign ram_w_addr = w_addr_q;
    assign ram_a_rden = rden_q;
    assign ram_w_rden = rden_q;
    assign en_mult    = en_mult_q;
    assign en_accum   = en_accum_q;
    assign clr_mult   = clr_q;
    assign clr_accum  = clr_q;
    assign ram_c_wren = wren_q;
    assign ram_c_addr = c_addr_q;

endmodule
